// File: rtl/pipelined_alu_if.sv
// Operand/result bundle for pipelined_alu: valid/ready operand channel in, valid/ready result channel out.
// Latency: none, wires only.
// Backpressure: in_ready/out_ready travel against the data direction.
interface pipelined_alu_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic             set_flags;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       res_flags;
  logic [3:0]       flags;
  logic             illegal;

  // ALU side
  modport slave (
    input  in_valid, op, set_flags, a, b, out_ready,
    output in_ready, out_valid, result, res_flags, flags, illegal
  );

  // Producer/consumer side
  modport master (
    output in_valid, op, set_flags, a, b, out_ready,
    input  in_ready, out_valid, result, res_flags, flags, illegal
  );
endinterface

// File: rtl/pipelined_alu.sv
// Execute-stage ALU: add/sub/logic/shifts in one cycle, iterative shift-add MUL, architectural flag register.
// Latency: non-MUL result valid after the accepting edge; MUL result valid WIDTH+1 edges after acceptance.
// Backpressure: one-entry result register; in_ready drops while a MUL runs or an unconsumed result is held.
module pipelined_alu #(
  parameter int WIDTH = 64
) (
  input logic           clk,
  input logic           reset_n,
  pipelined_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_PASS_B = 4'b0000;
  localparam logic [3:0] OP_ADD    = 4'b0010;
  localparam logic [3:0] OP_SUB    = 4'b0011;
  localparam logic [3:0] OP_AND    = 4'b0100;
  localparam logic [3:0] OP_OR     = 4'b0101;
  localparam logic [3:0] OP_XOR    = 4'b0110;
  localparam logic [3:0] OP_LSL    = 4'b0111;
  localparam logic [3:0] OP_LSR    = 4'b1000;
  localparam logic [3:0] OP_ASR    = 4'b1001;
  localparam logic [3:0] OP_MUL    = 4'b1010;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  logic [SHW:0]       r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic               r_sf;
  logic               r_rdy_en;
  logic               r_out_vld;
  logic [WIDTH-1:0]   r_result;
  logic [3:0]         r_res_flags;
  logic [3:0]         r_flags;
  logic               r_illegal;

  logic [SHW-1:0]     w_sh;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic [WIDTH:0]     w_lsl;
  logic [WIDTH:0]     w_lsr;
  logic [WIDTH:0]     w_asr;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;
  logic               w_ill;
  logic [3:0]         w_fl;
  logic [WIDTH-1:0]   w_mul_res;
  logic [3:0]         w_mul_fl;
  logic               w_accept;
  logic               w_consume;

  assign w_sh = bus.b[SHW-1:0];
  assign w_add = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_sub = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
  // Shifts carry one guard bit so the last bit shifted out falls into it; amount 0 leaves it 0.
  assign w_lsl = {1'b0, bus.a} << w_sh;
  assign w_lsr = {bus.a, 1'b0} >> w_sh;
  assign w_asr = $signed({bus.a, 1'b0}) >>> w_sh;

  assign w_mul_res = r_acc[WIDTH-1:0];
  assign w_mul_fl  = {w_mul_res[WIDTH-1], (w_mul_res == '0), |r_acc[2*WIDTH-1:WIDTH], 1'b0};

  assign w_accept  = bus.in_valid && bus.in_ready;
  assign w_consume = r_out_vld && bus.out_ready;

  // r_rdy_en keeps in_ready low until the first edge after reset release.
  assign bus.in_ready  = r_rdy_en && (r_state == S_IDLE) && (!r_out_vld || bus.out_ready);
  assign bus.out_valid = r_out_vld;
  assign bus.result    = r_result;
  assign bus.res_flags = r_res_flags;
  assign bus.flags     = r_flags;
  assign bus.illegal   = r_illegal;

  // Single-cycle result and flags for every opcode except MUL.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_ill = 1'b0;
    case (bus.op)
      OP_PASS_B: w_res = bus.b;
      OP_ADD: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_add[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_sub[WIDTH-1:0];
        w_c   = w_sub[WIDTH];
        w_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_sub[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  w_res = bus.a & bus.b;
      OP_OR:   w_res = bus.a | bus.b;
      OP_XOR:  w_res = bus.a ^ bus.b;
      OP_LSL:  {w_c, w_res} = w_lsl;
      OP_LSR:  {w_res, w_c} = w_lsr;
      OP_ASR:  {w_res, w_c} = w_asr;
      OP_MUL:  w_res = '0;
      default: w_ill = 1'b1;
    endcase
    w_fl = {w_res[WIDTH-1], (w_res == '0), w_v, w_c};
  end

  // Control FSM, MUL datapath, result register and architectural flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_sf        <= 1'b0;
      r_rdy_en    <= 1'b0;
      r_out_vld   <= 1'b0;
      r_result    <= '0;
      r_res_flags <= '0;
      r_flags     <= '0;
      r_illegal   <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      // A write below in the same cycle overrides this clear.
      if (w_consume) r_out_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (bus.op == OP_MUL) begin
              r_state  <= S_RUN;
              r_cnt    <= (SHW+1)'(WIDTH);
              r_acc    <= '0;
              r_mcand  <= {{WIDTH{1'b0}}, bus.a};
              r_mplier <= bus.b;
              r_sf     <= bus.set_flags;
            end else begin
              r_result    <= w_res;
              r_res_flags <= w_fl;
              r_illegal   <= w_ill;
              r_out_vld   <= 1'b1;
              if (bus.set_flags) r_flags <= w_fl;
            end
          end
        end
        S_RUN: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - 1'b1;
          if (r_cnt == (SHW+1)'(1)) r_state <= S_DONE;
        end
        S_DONE: begin
          r_result    <= w_mul_res;
          r_res_flags <= w_mul_fl;
          r_illegal   <= 1'b0;
          r_out_vld   <= 1'b1;
          if (r_sf) r_flags <= w_mul_fl;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pipelined_alu.sv
// Bench for pipelined_alu: a 64-bit and an 8-bit instance, directed vectors, arithmetic reference model.
// Latency: model predicts the edge at which each result must be written.
// Backpressure: out_ready is held low on the 64-bit instance to exercise the hold path.
module tb_pipelined_alu;
  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_pass;

  pipelined_alu_if #(.WIDTH(64)) if64();
  pipelined_alu_if #(.WIDTH(8))  if8();

  pipelined_alu #(.WIDTH(64)) u64 (.clk(clk), .reset_n(reset_n), .bus(if64));
  pipelined_alu #(.WIDTH(8))  u8  (.clk(clk), .reset_n(reset_n), .bus(if8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference: {illegal, N, Z, V, C, result} from plain wide arithmetic on w-bit operands.
  function automatic logic [68:0] calc(int w, logic [3:0] op, logic [63:0] a, logic [63:0] b);
    logic [127:0] mask, av, bv, half, r;
    logic signed [127:0] sa, sb, ss, smax, smin;
    logic c, v, ill, n, z;
    int s;
    mask = (128'd1 << w) - 128'd1;
    av   = {64'd0, a} & mask;
    bv   = {64'd0, b} & mask;
    half = 128'd1 << (w - 1);
    sa   = $signed((av ^ half) - half);
    sb   = $signed((bv ^ half) - half);
    smax = $signed(half) - 1;
    smin = -$signed(half);
    s    = int'(bv[31:0]) % w;
    r = '0; c = 1'b0; v = 1'b0; ill = 1'b0;
    case (op)
      4'h0: r = bv;
      4'h2: begin r = av + bv; c = r[w]; ss = sa + sb; v = (ss > smax) || (ss < smin); end
      4'h3: begin r = av + (~bv & mask) + 128'd1; c = r[w]; ss = sa - sb; v = (ss > smax) || (ss < smin); end
      4'h4: r = av & bv;
      4'h5: r = av | bv;
      4'h6: r = av ^ bv;
      4'h7: begin r = av << s; c = (s != 0) ? av[w-s] : 1'b0; end
      4'h8: begin r = av >> s; c = (s != 0) ? av[s-1] : 1'b0; end
      4'h9: begin r = sa >>> s; c = (s != 0) ? av[s-1] : 1'b0; end
      4'hA: begin r = av * bv; v = ((r >> w) != 0); end
      default: ill = 1'b1;
    endcase
    r = r & mask;
    n = r[w-1];
    z = (r == 0);
    return {ill, n, z, v, c, r[63:0]};
  endfunction

  // Model state per instance (0 = 64-bit, 1 = 8-bit).
  logic        m_ov   [2];
  logic        m_cons [2];
  logic [68:0] m_out  [2];
  logic [3:0]  m_fl   [2];
  logic        p_vld  [2];
  logic        p_sf   [2];
  logic [68:0] p_out  [2];
  int          p_due  [2];
  int          cyc    [2];

  task automatic model_step(int d, int w, logic ov, logic [63:0] res, logic [3:0] rf, logic il,
                            logic [3:0] fl, logic ir, logic iv, logic orr, logic [3:0] op,
                            logic sf, logic [63:0] a, logic [63:0] b);
    string t;
    logic exp_ir;
    t = (d == 0) ? "w64" : "w8";
    if (!reset_n) begin
      m_ov[d] = 1'b0; m_cons[d] = 1'b0; m_fl[d] = 4'd0; p_vld[d] = 1'b0;
      chk({t, " rst out_valid"}, ov, 0);
      chk({t, " rst result"}, res, 0);
      chk({t, " rst res_flags"}, rf, 0);
      chk({t, " rst illegal"}, il, 0);
      chk({t, " rst flags"}, fl, 0);
    end else begin
      cyc[d]++;
      if (m_cons[d]) m_ov[d] = 1'b0;
      if (p_vld[d] && p_due[d] == cyc[d]) begin
        m_ov[d]  = 1'b1;
        m_out[d] = p_out[d];
        if (p_sf[d]) m_fl[d] = p_out[d][67:64];
        p_vld[d] = 1'b0;
      end
      chk({t, " out_valid"}, ov, m_ov[d]);
      if (m_ov[d]) begin
        chk({t, " result"}, res, m_out[d][63:0]);
        chk({t, " res_flags"}, rf, m_out[d][67:64]);
        chk({t, " illegal"}, il, m_out[d][68]);
      end
      chk({t, " flags"}, fl, m_fl[d]);
      exp_ir = !p_vld[d] && (!m_ov[d] || orr);
      chk({t, " in_ready"}, ir, exp_ir);
      m_cons[d] = m_ov[d] && orr;
      if (iv && exp_ir) begin
        p_vld[d] = 1'b1;
        p_sf[d]  = sf;
        p_out[d] = calc(w, op, a, b);
        p_due[d] = cyc[d] + 1 + ((op == 4'hA) ? w + 1 : 0);
      end
    end
  endtask

  // Compare process: every falling edge, both instances against the model.
  always @(negedge clk) begin
    model_step(0, 64, if64.out_valid, if64.result, if64.res_flags, if64.illegal, if64.flags,
               if64.in_ready, if64.in_valid, if64.out_ready, if64.op, if64.set_flags, if64.a, if64.b);
    model_step(1, 8, if8.out_valid, {56'd0, if8.result}, if8.res_flags, if8.illegal, if8.flags,
               if8.in_ready, if8.in_valid, if8.out_ready, if8.op, if8.set_flags,
               {56'd0, if8.a}, {56'd0, if8.b});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive64(logic v, logic [3:0] op, logic [63:0] a, logic [63:0] b, logic sf);
    if64.in_valid = v; if64.op = op; if64.a = a; if64.b = b; if64.set_flags = sf;
  endtask

  task automatic drive8(logic v, logic [3:0] op, logic [7:0] a, logic [7:0] b, logic sf);
    if8.in_valid = v; if8.op = op; if8.a = a; if8.b = b; if8.set_flags = sf;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    for (int i = 0; i < 2; i++) begin
      m_ov[i] = 0; m_cons[i] = 0; m_out[i] = '0; m_fl[i] = 0;
      p_vld[i] = 0; p_sf[i] = 0; p_out[i] = '0; p_due[i] = 0; cyc[i] = 0;
    end
    drive64(0, 4'h0, 0, 0, 0); if64.out_ready = 1'b1;
    drive8(0, 4'h0, 0, 0, 0);  if8.out_ready = 1'b1;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    chk("reset out_valid", if64.out_valid, 0);
    chk("reset flags", if64.flags, 0);

    // Pin the reference model with hand-computed values.
    chk("model add", calc(64, 4'h2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1), {1'b0, 4'hA, 64'h8000_0000_0000_0000});
    chk("model sub", calc(64, 4'h3, 64'd5, 64'd5), {1'b0, 4'h5, 64'd0});
    chk("model asr", calc(64, 4'h9, 64'h8000_0000_0000_0000, 64'h43), {1'b0, 4'h8, 64'hF000_0000_0000_0000});
    chk("model mul8", calc(8, 4'hA, 64'h10, 64'h11), {1'b0, 4'h2, 64'h10});
    chk("model illegal", calc(64, 4'hF, 64'd9, 64'd9), {1'b1, 4'h4, 64'd0});

    #19 reset_n = 1'b1;
    tick();
    chk("in_ready after release", if64.in_ready, 1);

    // ADD overflow into the sign bit, flags committed.
    drive64(1, 4'h2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1);
    tick();
    chk("add result", if64.result, 64'h8000_0000_0000_0000);
    chk("add res_flags", if64.res_flags, 4'b1010);
    chk("add flags", if64.flags, 4'b1010);

    // SUB to zero without committing flags.
    drive64(1, 4'h3, 64'd5, 64'd5, 0);
    tick();
    chk("sub result", if64.result, 64'd0);
    chk("sub res_flags", if64.res_flags, 4'b0101);
    chk("sub flags kept", if64.flags, 4'b1010);

    // Back-to-back shifts.
    drive64(1, 4'h7, 64'h8000_0000_0000_0001, 64'd1, 0);
    tick();
    chk("lsl result", if64.result, 64'h2);
    chk("lsl res_flags", if64.res_flags, 4'b0001);
    chk("lsl in_ready", if64.in_ready, 1);
    drive64(1, 4'h9, 64'h8000_0000_0000_0000, 64'h43, 0);
    tick();
    chk("asr result", if64.result, 64'hF000_0000_0000_0000);
    chk("asr res_flags", if64.res_flags, 4'b1000);
    drive64(0, 4'h0, 0, 0, 0);
    tick();

    // 8-bit MUL with overflow, then a small MUL.
    drive8(1, 4'hA, 8'h10, 8'h11, 1);
    tick();
    drive8(0, 4'h0, 0, 0, 0);
    chk("mul busy 0", if8.in_ready, 0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("mul busy", if8.in_ready, 0);
      chk("mul not done", if8.out_valid, 0);
    end
    tick();
    chk("mul done", if8.out_valid, 1);
    chk("mul result", if8.result, 8'h10);
    chk("mul res_flags", if8.res_flags, 4'b0010);
    chk("mul flags", if8.flags, 4'b0010);
    drive8(1, 4'hA, 8'h03, 8'h04, 1);
    tick();
    drive8(0, 4'h0, 0, 0, 0);
    repeat (9) tick();
    chk("mul2 result", if8.result, 8'h0C);
    chk("mul2 res_flags", if8.res_flags, 4'b0000);

    // Backpressure: XOR result held for 5 cycles, then consume and accept together.
    if64.out_ready = 1'b0;
    drive64(1, 4'h6, 64'hF0, 64'hFF, 0);
    tick();
    drive64(0, 4'h0, 0, 0, 0);
    chk("xor result", if64.result, 64'h0F);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold result", if64.result, 64'h0F);
      chk("hold in_ready", if64.in_ready, 0);
    end
    if64.out_ready = 1'b1;
    drive64(1, 4'h5, 64'd1, 64'd2, 0);
    #1;
    chk("release in_ready", if64.in_ready, 1);
    tick();
    chk("or result", if64.result, 64'd3);
    chk("or out_valid", if64.out_valid, 1);

    // Undefined opcode commits Z only.
    drive64(1, 4'hF, 64'd9, 64'd9, 1);
    tick();
    chk("illegal flag", if64.illegal, 1);
    chk("illegal result", if64.result, 0);
    chk("illegal flags", if64.flags, 4'b0100);

    // Reset in the middle of a 64-bit MUL.
    drive64(1, 4'hA, 64'd3, 64'd5, 1);
    tick();
    drive64(0, 4'h0, 0, 0, 0);
    repeat (10) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("async rst out_valid", if64.out_valid, 0);
    chk("async rst flags", if64.flags, 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    tick();
    chk("post-reset in_ready", if64.in_ready, 1);
    chk("post-reset out_valid", if64.out_valid, 0);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
